// File: rtl/loc_sram_writer_pkg.sv
// loc_wr_pkg: shared geometry, FSM state type and lane-to-mask helper for the
// location SRAM write-coalescing stage (loc_sram_writer).
//   D       lanes (vertices) per SRAM row
//   BW      bits per location value
//   ROW_AW  SRAM row address width
//   LANE_AW lane index width
package loc_wr_pkg;

  localparam int unsigned D       = 256;
  localparam int unsigned BW      = 5;
  localparam int unsigned ROW_AW  = 4;
  localparam int unsigned LANE_AW = 8;
  localparam int unsigned VID_W   = ROW_AW + LANE_AW;
  localparam int unsigned POS_W   = $clog2(D * BW);

  typedef enum logic [1:0] {
    EMPTY,
    ACCUM,
    FLUSH
  } wr_state_e;

  // Lane 0 sits in the MSB slice, so its mask bit is D-1.
  function automatic logic [LANE_AW-1:0] mask_idx(input logic [LANE_AW-1:0] lane);
    return LANE_AW'(D - 1) - lane;
  endfunction

endpackage

// File: rtl/loc_sram_writer_if.sv
// loc_sram_writer_if: update stream, flush handshake and SRAM write bus.
//   in_valid/in_ready/in_vid/in_loc  single-vertex location update
//   flush/flush_done                 write-out request and completion pulse
//   wsb/bytemask/wdata/waddr         SRAM write port (wsb and keep-mask active low)
// master: update producer / SRAM observer side; slave: loc_sram_writer.
interface loc_sram_writer_if;
  import loc_wr_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [VID_W-1:0]  in_vid;
  logic [BW-1:0]     in_loc;
  logic              flush;
  logic              flush_done;
  logic              wsb;
  logic [D-1:0]      bytemask;
  logic [D*BW-1:0]   wdata;
  logic [ROW_AW-1:0] waddr;

  modport master (
    output in_valid, in_vid, in_loc, flush,
    input  in_ready, flush_done, wsb, bytemask, wdata, waddr
  );

  modport slave (
    input  in_valid, in_vid, in_loc, flush,
    output in_ready, flush_done, wsb, bytemask, wdata, waddr
  );

endinterface

// File: rtl/loc_sram_writer_lane_dec.sv
// loc_lane_dec: lane index to active-low one-hot keep mask and the bit
// position of the lane's BW-wide slice inside a row of data.
//   lane    lane index within the row
//   mask_n  D-bit mask, 0 only at the lane's bit (mask_idx(lane))
//   pos     low bit of the lane's slice in the D*BW data word
module loc_lane_dec
  import loc_wr_pkg::*;
(
  input  logic [LANE_AW-1:0] lane,
  output logic [D-1:0]       mask_n,
  output logic [POS_W-1:0]   pos
);

  always_comb begin
    mask_n                 = '1;
    mask_n[mask_idx(lane)] = 1'b0;
    pos                    = POS_W'(mask_idx(lane)) * POS_W'(BW);
  end

endmodule

// File: rtl/loc_sram_writer.sv
// loc_sram_writer: coalesces single-vertex location updates that hit the same
// SRAM row into a row buffer and issues one masked row write per row change
// or flush (and per idle timeout when LOC_WR_TIMEOUT_EN is defined).
//   clk, rst  clock; synchronous active-high reset
//   bus       loc_sram_writer_if.slave: update stream, flush/flush_done,
//             registered SRAM outputs wsb/bytemask/wdata/waddr
// Optional: LOC_WR_TIMEOUT_EN adds an idle counter (TIMEOUT cycles) that
// writes the pending row out without flush_done.
module loc_sram_writer
  import loc_wr_pkg::*;
`ifdef LOC_WR_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 16
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  loc_sram_writer_if.slave  bus
);

  wr_state_e         state_q, state_d;
  logic [D*BW-1:0]   buf_data_q, buf_data_d;
  logic [D-1:0]      buf_mask_q, buf_mask_d;
  logic [ROW_AW-1:0] buf_row_q, buf_row_d;
  logic              wsb_q, wsb_d;
  logic [D-1:0]      bytemask_q, bytemask_d;
  logic [D*BW-1:0]   wdata_q, wdata_d;
  logic [ROW_AW-1:0] waddr_q, waddr_d;
  logic              flush_done_q, flush_done_d;

`ifdef LOC_WR_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  logic              in_ready;
  logic              accept;
  logic [ROW_AW-1:0] in_row;
  logic [D-1:0]      lane_mask_n;
  logic [POS_W-1:0]  lane_pos;

  assign in_row   = bus.in_vid[LANE_AW +: ROW_AW];
  assign in_ready = ~bus.flush & (state_q != FLUSH);
  assign accept   = bus.in_valid & in_ready;

  loc_lane_dec u_lane_dec (
    .lane   (bus.in_vid[LANE_AW-1:0]),
    .mask_n (lane_mask_n),
    .pos    (lane_pos)
  );

  always_comb begin
    state_d      = state_q;
    buf_data_d   = buf_data_q;
    buf_mask_d   = buf_mask_q;
    buf_row_d    = buf_row_q;
    wsb_d        = 1'b1;
    bytemask_d   = '1;
    wdata_d      = wdata_q;
    waddr_d      = waddr_q;
    flush_done_d = 1'b0;
`ifdef LOC_WR_TIMEOUT_EN
    idle_d       = idle_q;
`endif

    case (state_q)
      EMPTY: begin
        if (bus.flush) begin
          flush_done_d = 1'b1;
          state_d      = FLUSH;
        end else if (accept) begin
          buf_row_d                 = in_row;
          buf_data_d                = '0;
          buf_data_d[lane_pos +: BW] = bus.in_loc;
          buf_mask_d                = lane_mask_n;
          state_d                   = ACCUM;
`ifdef LOC_WR_TIMEOUT_EN
          idle_d                    = '0;
`endif
        end
      end

      ACCUM: begin
        if (bus.flush) begin
          wsb_d        = 1'b0;
          bytemask_d   = buf_mask_q;
          wdata_d      = buf_data_q;
          waddr_d      = buf_row_q;
          flush_done_d = 1'b1;
          buf_data_d   = '0;
          buf_mask_d   = '1;
          buf_row_d    = '0;
          state_d      = FLUSH;
        end else if (accept) begin
          if (in_row == buf_row_q) begin
            buf_data_d[lane_pos +: BW] = bus.in_loc;
            buf_mask_d                 = buf_mask_q & lane_mask_n;
          end else begin
            // Old row goes out while the buffer restarts with just the new lane.
            wsb_d                      = 1'b0;
            bytemask_d                 = buf_mask_q;
            wdata_d                    = buf_data_q;
            waddr_d                    = buf_row_q;
            buf_row_d                  = in_row;
            buf_data_d                 = '0;
            buf_data_d[lane_pos +: BW] = bus.in_loc;
            buf_mask_d                 = lane_mask_n;
          end
`ifdef LOC_WR_TIMEOUT_EN
          idle_d = '0;
`endif
        end
`ifdef LOC_WR_TIMEOUT_EN
        else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          wsb_d      = 1'b0;
          bytemask_d = buf_mask_q;
          wdata_d    = buf_data_q;
          waddr_d    = buf_row_q;
          buf_data_d = '0;
          buf_mask_d = '1;
          buf_row_d  = '0;
          idle_d     = '0;
          state_d    = EMPTY;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
      end

      FLUSH: begin
        state_d = EMPTY;
      end

      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      buf_data_q   <= '0;
      buf_mask_q   <= '1;
      buf_row_q    <= '0;
      wsb_q        <= 1'b1;
      bytemask_q   <= '1;
      wdata_q      <= '0;
      waddr_q      <= '0;
      flush_done_q <= 1'b0;
`ifdef LOC_WR_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      buf_data_q   <= buf_data_d;
      buf_mask_q   <= buf_mask_d;
      buf_row_q    <= buf_row_d;
      wsb_q        <= wsb_d;
      bytemask_q   <= bytemask_d;
      wdata_q      <= wdata_d;
      waddr_q      <= waddr_d;
      flush_done_q <= flush_done_d;
`ifdef LOC_WR_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.wsb        = wsb_q;
  assign bus.bytemask   = bytemask_q;
  assign bus.wdata      = wdata_q;
  assign bus.waddr      = waddr_q;
  assign bus.flush_done = flush_done_q;

endmodule

// File: tb/tb_loc_sram_writer.sv
// tb_loc_sram_writer: directed bench for loc_sram_writer. Inputs change 1 time
// unit after the rising edge; a negedge monitor logs every SRAM write and
// flush_done pulse. Builds with or without LOC_WR_TIMEOUT_EN.
module tb_loc_sram_writer;
  import loc_wr_pkg::*;

  logic clk;
  logic rst;

  loc_sram_writer_if bus ();

  loc_sram_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write / flush_done log, sampled on the falling edge.
  int                cyc    = 0;
  int                wr_cnt = 0;
  int                fd_cnt = 0;
  int                wr_cyc = 0;
  int                fd_cyc = 0;
  logic [D-1:0]      last_mask;
  logic [D*BW-1:0]   last_data;
  logic [ROW_AW-1:0] last_addr;

  always @(negedge clk) begin
    cyc++;
    if (bus.wsb === 1'b0) begin
      wr_cnt++;
      wr_cyc    = cyc;
      last_mask = bus.bytemask;
      last_data = bus.wdata;
      last_addr = bus.waddr;
    end
    if (bus.flush_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  function automatic logic [BW-1:0] slice_of(input logic [D*BW-1:0] d, input int lane);
    return d[(D - 1 - lane) * BW +: BW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [VID_W-1:0] vid, input logic [BW-1:0] loc);
    bus.in_valid = 1'b1;
    bus.in_vid   = vid;
    bus.in_loc   = loc;
    chk("send_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int w0, f0;

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_vid   = '0;
    bus.in_loc   = '0;
    bus.flush    = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset state
    chk("rst_wsb",      64'(bus.wsb), 64'd1);
    chk("rst_mask",     64'($countones(~bus.bytemask)), 64'd0);
    chk("rst_wdata",    64'(|bus.wdata), 64'd0);
    chk("rst_waddr",    64'(bus.waddr), 64'd0);
    chk("rst_fdone",    64'(bus.flush_done), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Merge two lanes of row 0, then flush
    w0 = wr_cnt; f0 = fd_cnt;
    send(12'h012, 5'd3);
    send(12'h0FF, 5'd7);
    chk("t1_no_early_wr", 64'(wr_cnt - w0), 64'd0);
    do_flush();
    chk("t1_wsb_low", 64'(bus.wsb), 64'd0);
    chk("t1_fdone",   64'(bus.flush_done), 64'd1);
    idle(1);
    chk("t1_wsb_high",  64'(bus.wsb), 64'd1);
    chk("t1_fdone_off", 64'(bus.flush_done), 64'd0);
    chk("t1_wr_cnt",    64'(wr_cnt - w0), 64'd1);
    chk("t1_fd_cnt",    64'(fd_cnt - f0), 64'd1);
    chk("t1_waddr",     64'(last_addr), 64'd0);
    chk("t1_mask_zeros", 64'($countones(~last_mask)), 64'd2);
    chk("t1_mask237",   64'(last_mask[237]), 64'd0);
    chk("t1_mask0",     64'(last_mask[0]), 64'd0);
    chk("t1_lane18",    64'(slice_of(last_data, 18)), 64'd3);
    chk("t1_lane255",   64'(slice_of(last_data, 255)), 64'd7);
    // flush_done asserts on the same cycle as the flush write
    chk("t1_fd_with_wr", 64'(fd_cyc - wr_cyc), 64'd0);

    // Row change on back-to-back accepts
    w0 = wr_cnt;
    send(12'h105, 5'd1);
    send(12'h205, 5'd2);
    chk("t2_wsb_low",     64'(bus.wsb), 64'd0);
    chk("t2_waddr",       64'(bus.waddr), 64'd1);
    chk("t2_mask_zeros",  64'($countones(~bus.bytemask)), 64'd1);
    chk("t2_mask250",     64'(bus.bytemask[250]), 64'd0);
    chk("t2_lane5",       64'(slice_of(bus.wdata, 5)), 64'd1);
    idle(1);
    chk("t2_idle_wsb",    64'(bus.wsb), 64'd1);
    chk("t2_idle_mask",   64'($countones(~bus.bytemask)), 64'd0);
    chk("t2_wdata_held",  64'(slice_of(bus.wdata, 5)), 64'd1);
    do_flush();
    idle(1);
    chk("t2_wr_cnt",      64'(wr_cnt - w0), 64'd2);
    chk("t2_flush_waddr", 64'(last_addr), 64'd2);
    chk("t2_flush_mask",  64'(last_mask[250]), 64'd0);
    chk("t2_flush_lane5", 64'(slice_of(last_data, 5)), 64'd2);

    // Same lane written twice: last value wins
    w0 = wr_cnt;
    send(12'h300, 5'd4);
    send(12'h300, 5'd9);
    do_flush();
    idle(1);
    chk("t3_wr_cnt",     64'(wr_cnt - w0), 64'd1);
    chk("t3_waddr",      64'(last_addr), 64'd3);
    chk("t3_lane0",      64'(slice_of(last_data, 0)), 64'd9);
    chk("t3_mask255",    64'(last_mask[255]), 64'd0);
    chk("t3_mask_zeros", 64'($countones(~last_mask)), 64'd1);

    // Flush in EMPTY with in_valid high: blocked, no write
    w0 = wr_cnt; f0 = fd_cnt;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_vid   = 12'h0AA;
    bus.in_loc   = 5'd17;
    #1;
    chk("t4_ready_low", 64'(bus.in_ready), 64'd0);
    step();
    chk("t4_fdone",       64'(bus.flush_done), 64'd1);
    chk("t4_wsb",         64'(bus.wsb), 64'd1);
    chk("t4_ready_flush", 64'(bus.in_ready), 64'd0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("t4_fdone_off", 64'(bus.flush_done), 64'd0);
    do_flush();
    idle(1);
    chk("t4_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("t4_fd_cnt",   64'(fd_cnt - f0), 64'd2);

    // Flush held for four cycles: two FLUSH passes
    w0 = wr_cnt; f0 = fd_cnt;
    bus.flush = 1'b1;
    idle(4);
    bus.flush = 1'b0;
    idle(1);
    chk("t5_held_fd",  64'(fd_cnt - f0), 64'd2);
    chk("t5_held_wr",  64'(wr_cnt - w0), 64'd0);

    // Reset with a pending row discards it
    w0 = wr_cnt; f0 = fd_cnt;
    send(12'h123, 5'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_wsb",   64'(bus.wsb), 64'd1);
    chk("t6_rst_wdata", 64'(|bus.wdata), 64'd0);
    do_flush();
    chk("t6_fdone", 64'(bus.flush_done), 64'd1);
    idle(2);
    chk("t6_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("t6_fd_cnt",   64'(fd_cnt - f0), 64'd1);

`ifdef LOC_WR_TIMEOUT_EN
    // One update then 16 idle cycles: auto write, no flush_done
    w0 = wr_cnt; f0 = fd_cnt;
    send(12'h040, 5'd5);
    idle(15);
    chk("to_not_yet", 64'(wr_cnt - w0), 64'd0);
    idle(1);
    chk("to_wsb",   64'(bus.wsb), 64'd0);
    chk("to_fdone", 64'(bus.flush_done), 64'd0);
    chk("to_waddr", 64'(bus.waddr), 64'd0);
    chk("to_lane64", 64'(slice_of(bus.wdata, 64)), 64'd5);
    idle(1);
    chk("to_fd_cnt", 64'(fd_cnt - f0), 64'd0);
    // Accept on idle cycle 15 restarts the count
    w0 = wr_cnt;
    send(12'h041, 5'd1);
    idle(14);
    send(12'h042, 5'd2);
    idle(15);
    chk("to_restart_none", 64'(wr_cnt - w0), 64'd0);
    idle(1);
    chk("to_restart_wsb",   64'(bus.wsb), 64'd0);
    chk("to_restart_zeros", 64'($countones(~bus.bytemask)), 64'd2);
    idle(1);
    // Back in EMPTY: a flush must not write again
    w0 = wr_cnt;
    do_flush();
    idle(1);
    chk("to_empty_after", 64'(wr_cnt - w0), 64'd0);
`else
    // No timeout: a pending row stays put while idle
    w0 = wr_cnt;
    send(12'h040, 5'd5);
    idle(20);
    chk("nto_no_write", 64'(wr_cnt - w0), 64'd0);
    do_flush();
    idle(1);
    chk("nto_flush_wr",  64'(wr_cnt - w0), 64'd1);
    chk("nto_lane64",    64'(slice_of(last_data, 64)), 64'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
